// File: rtl/sram_stream_pkg.sv
// Shared encodings and sizing constants for the SRAM-backed stream buffer.
package sram_stream_pkg;

    // Arbitration priority between the write and read sides of the SRAM port.
    typedef enum logic {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } prio_e;

    // Entries in the read-return buffer that decouples output back-pressure from the SRAM.
    localparam int OBUF_DEPTH = 2;

endpackage

// File: rtl/sram_stream_obuf.sv
// Two-entry output FIFO holding SRAM read returns; head entry drives the read stream.
module sram_stream_obuf
    import sram_stream_pkg::*;
#(
    parameter int BW_DATA = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [BW_DATA-1:0] i_data,
    input  logic               i_pop,
    output logic               o_valid,
    output logic [BW_DATA-1:0] o_data,
    output logic [1:0]         o_occ
);

    logic [BW_DATA-1:0] head_q, head_d;
    logic [BW_DATA-1:0] tail_q, tail_d;
    logic [1:0]         occ_q, occ_d;
    logic               pop_ok;

    // Next-state: pop shifts tail into head; push lands in the first free slot after the pop.
    always_comb begin
        pop_ok = i_pop && (occ_q != 2'd0);
        head_d = head_q;
        tail_d = tail_q;
        if (pop_ok) begin
            head_d = tail_q;
        end
        if (i_push) begin
            if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop_ok)) begin
                head_d = i_data;
            end else begin
                tail_d = i_data;
            end
        end
        occ_d = occ_q + 2'(i_push) - 2'(pop_ok);
    end

    // State register; reset empties the buffer and zeroes the presented word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign o_valid = (occ_q != 2'd0);
    assign o_data  = head_q;
    assign o_occ   = occ_q;

    // Depth sanity: the buffer must never be asked to hold more than OBUF_DEPTH words.
    localparam logic [1:0] OCC_MAX = 2'(OBUF_DEPTH);
    logic unused_ok;
    assign unused_ok = (occ_q <= OCC_MAX);

endmodule

// File: rtl/sram_stream_buffer.sv
// Stream FIFO controller multiplexing one single-port SRAM between writes and reads.
module sram_stream_buffer
    import sram_stream_pkg::*;
#(
    parameter int BW_DATA = 64,
    parameter int BW_ADDR = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [BW_DATA-1:0] i_in_data,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [BW_DATA-1:0] o_out_data,
    output logic [BW_ADDR:0]   o_count,
    output logic [BW_ADDR-1:0] o_sram_addr,
    output logic [BW_DATA-1:0] o_sram_data,
    output logic               o_sram_wen,
    output logic               o_sram_oen,
    input  logic [BW_DATA-1:0] i_sram_data
);

    localparam int DEPTH = 2 ** BW_ADDR;

    logic [BW_ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [BW_ADDR-1:0] rd_ptr_q, rd_ptr_d;
    logic [BW_ADDR:0]   count_q, count_d;
    prio_e              prio_q, prio_d;
    logic               rd_inflight_q, rd_inflight_d;

    logic [1:0] obuf_occ;
    logic       obuf_pop;
    logic       full, empty, rd_want, rd_issue, wr_issue;

    // Arbitration, SRAM pin drive and next-state; read credit counts buffered plus in-flight words.
    always_comb begin
        full       = (count_q == (BW_ADDR+1)'(DEPTH));
        empty      = (count_q == '0);
        rd_want    = !empty && ((obuf_occ + {1'b0, rd_inflight_q}) < 2'(OBUF_DEPTH));
        rd_issue   = rd_want && ((prio_q == PRIO_RD) || !(i_in_valid && !full));
        o_in_ready = !full && !(rd_want && (prio_q == PRIO_RD));
        wr_issue   = i_in_valid && o_in_ready;

        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        prio_d        = prio_q;
        rd_inflight_d = rd_issue;
        o_sram_addr   = '0;
        o_sram_data   = '0;
        o_sram_wen    = 1'b0;
        o_sram_oen    = 1'b0;

        if (wr_issue) begin
            o_sram_wen  = 1'b1;
            o_sram_addr = wr_ptr_q;
            o_sram_data = i_in_data;
            wr_ptr_d    = wr_ptr_q + (BW_ADDR)'(1);
            count_d     = count_q + (BW_ADDR+1)'(1);
        end else if (rd_issue) begin
            o_sram_oen  = 1'b1;
            o_sram_addr = rd_ptr_q;
            rd_ptr_d    = rd_ptr_q + (BW_ADDR)'(1);
            count_d     = count_q - (BW_ADDR+1)'(1);
        end

        // A write that beat a waiting read hands the next slot to the read side.
        if (wr_issue && rd_want) begin
            prio_d = PRIO_RD;
        end else if (rd_issue) begin
            prio_d = PRIO_WR;
        end
    end

    // Control state register; reset also drops any read return still in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            prio_q        <= PRIO_WR;
            rd_inflight_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            prio_q        <= prio_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    assign obuf_pop = o_out_valid && i_out_ready;
    assign o_count  = count_q;

    sram_stream_obuf #(
        .BW_DATA (BW_DATA)
    ) u_obuf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (rd_inflight_q),
        .i_data  (i_sram_data),
        .i_pop   (obuf_pop),
        .o_valid (o_out_valid),
        .o_data  (o_out_data),
        .o_occ   (obuf_occ)
    );

endmodule

// File: tb/tb_sram_stream_buffer.sv
// Directed bench for sram_stream_buffer with a behavioural single-port SRAM.
module tb_sram_stream_buffer;

    localparam int BW_DATA = 64;
    localparam int BW_ADDR = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [BW_DATA-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [BW_DATA-1:0] out_data;
    logic [BW_ADDR:0]   count;
    logic [BW_ADDR-1:0] sram_addr;
    logic [BW_DATA-1:0] sram_wdata;
    logic               sram_wen;
    logic               sram_oen;
    logic [BW_DATA-1:0] sram_rdata;

    logic [BW_DATA-1:0] mem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Single-port SRAM: write on wen, registered read data the cycle after oen.
    always @(posedge clk) begin
        if (sram_wen) mem[sram_addr] <= sram_wdata;
        if (sram_oen) sram_rdata <= mem[sram_addr];
    end

    sram_stream_buffer #(
        .BW_DATA (BW_DATA),
        .BW_ADDR (BW_ADDR)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_count     (count),
        .o_sram_addr (sram_addr),
        .o_sram_data (sram_wdata),
        .o_sram_wen  (sram_wen),
        .o_sram_oen  (sram_oen),
        .i_sram_data (sram_rdata)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++;
        if ({sram_wen, sram_oen} !== 2'b00) begin errors++; $display("FAIL reset_sram_en: got wen=%b oen=%b expected 0 0", sram_wen, sram_oen); end
        checks++;
        if (out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        next_cycle();
        rst = 1'b0;
        next_cycle();
        #1;
        checks++;
        if ({in_ready, out_valid, count} !== {1'b1, 1'b0, 7'd0}) begin
            errors++; $display("FAIL post_reset_state: got ready=%b valid=%b count=%0d expected 1 0 0", in_ready, out_valid, count);
        end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            checks++;
            if ({sram_wen, sram_oen, sram_addr, out_valid} !== '0 || sram_wdata !== 64'd0) begin
                errors++;
                $display("FAIL idle_cycle%0d: got wen=%b oen=%b addr=%0d data=%h valid=%b expected all 0", c, sram_wen, sram_oen, sram_addr, sram_wdata, out_valid);
            end
        end
    endtask

    task automatic test_single();
        logic [BW_DATA-1:0] word;
        word = 64'hDEAD_BEEF_0000_0001;
        next_cycle();
        in_valid = 1'b1; in_data = word; out_ready = 1'b1;
        #1;
        checks++;
        if ({in_ready, sram_wen, sram_addr} !== {1'b1, 1'b1, 6'd0} || sram_wdata !== word) begin
            errors++; $display("FAIL single_write: got ready=%b wen=%b addr=%0d data=%h expected 1 1 0 %h", in_ready, sram_wen, sram_addr, sram_wdata, word);
        end
        next_cycle();
        in_valid = 1'b0;
        #1;
        checks++;
        if ({sram_oen, sram_wen, sram_addr} !== {1'b1, 1'b0, 6'd0}) begin
            errors++; $display("FAIL single_read_t1: got oen=%b wen=%b addr=%0d expected 1 0 0", sram_oen, sram_wen, sram_addr);
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_t1: got %b expected 0", out_valid); end
        next_cycle();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_t2: got %b expected 0", out_valid); end
        next_cycle();
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== word) begin
            errors++; $display("FAIL single_out_t3: got valid=%b data=%h expected 1 %h", out_valid, out_data, word);
        end
        next_cycle();
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 7'd0) begin
            errors++; $display("FAIL single_after_pop: got valid=%b count=%0d expected 0 0", out_valid, count);
        end
    endtask

    task automatic test_fill_stall();
        int acc;
        int exp;
        acc = 0;
        for (int c = 0; c < 120; c++) begin
            next_cycle();
            in_valid = 1'b1; in_data = 64'(acc); out_ready = 1'b0;
            #1;
            if (in_ready) acc++;
        end
        checks++;
        if (acc !== 66) begin errors++; $display("FAIL fill_accepted: got %0d expected 66", acc); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (count !== 7'd64) begin errors++; $display("FAIL fill_count: got %0d expected 64", count); end
        exp = 0;
        for (int c = 0; c < 400 && exp < 66; c++) begin
            next_cycle();
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            if (out_valid) begin
                checks++;
                if (out_data !== 64'(exp)) begin errors++; $display("FAIL fill_drain_word%0d: got %h expected %h", exp, out_data, 64'(exp)); end
                exp++;
            end
        end
        checks++;
        if (exp !== 66) begin errors++; $display("FAIL fill_drain_count: got %0d expected 66", exp); end
        next_cycle();
        #1;
        checks++;
        if (count !== 7'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL fill_drained_state: got count=%0d valid=%b expected 0 0", count, out_valid);
        end
    endtask

    task automatic test_contention();
        int acc;
        int exp;
        int win_in;
        int win_out;
        logic prev_wen;
        acc = 0; exp = 0; win_in = 0; win_out = 0; prev_wen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            next_cycle();
            in_valid = 1'b1; in_data = 64'(acc); out_ready = 1'b1;
            #1;
            if (c >= 10 && c < 30) begin
                checks++;
                if ((sram_wen ^ sram_oen) !== 1'b1 || (c > 10 && sram_wen === prev_wen)) begin
                    errors++; $display("FAIL contention_alternate_c%0d: got wen=%b oen=%b prev_wen=%b expected one-hot toggling", c, sram_wen, sram_oen, prev_wen);
                end
                if (in_ready) win_in++;
                if (out_valid) win_out++;
            end
            prev_wen = sram_wen;
            if (out_valid) begin
                checks++;
                if (out_data !== 64'(exp)) begin errors++; $display("FAIL contention_word%0d: got %h expected %h", exp, out_data, 64'(exp)); end
                exp++;
            end
            if (in_ready) acc++;
        end
        checks++;
        if (win_in !== 10) begin errors++; $display("FAIL contention_in_rate: got %0d expected 10 per 20 cycles", win_in); end
        checks++;
        if (win_out !== 10) begin errors++; $display("FAIL contention_out_rate: got %0d expected 10 per 20 cycles", win_out); end
        for (int c = 0; c < 300 && exp < acc; c++) begin
            next_cycle();
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            if (out_valid) begin
                checks++;
                if (out_data !== 64'(exp)) begin errors++; $display("FAIL contention_drain_word%0d: got %h expected %h", exp, out_data, 64'(exp)); end
                exp++;
            end
        end
        checks++;
        if (exp !== acc) begin errors++; $display("FAIL contention_drain_count: got %0d expected %0d", exp, acc); end
    endtask

    task automatic test_wrap();
        int acc;
        int exp;
        int rd_cnt;
        int max_count;
        logic wrapped;
        acc = 0; exp = 0; rd_cnt = 0; max_count = 0; wrapped = 1'b0;
        next_cycle();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 5000 && exp < 200; c++) begin
            next_cycle();
            in_valid  = (acc < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data   = 64'(acc);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (int'(count) > max_count) max_count = int'(count);
            if (sram_wen) begin
                checks++;
                if (sram_addr !== acc[5:0]) begin errors++; $display("FAIL wrap_waddr%0d: got %0d expected %0d", acc, sram_addr, acc[5:0]); end
                if (sram_addr == 6'd0 && acc > 0) wrapped = 1'b1;
                acc++;
            end
            if (sram_oen) begin
                checks++;
                if (sram_addr !== rd_cnt[5:0]) begin errors++; $display("FAIL wrap_raddr%0d: got %0d expected %0d", rd_cnt, sram_addr, rd_cnt[5:0]); end
                rd_cnt++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== 64'(exp)) begin errors++; $display("FAIL wrap_word%0d: got %h expected %h", exp, out_data, 64'(exp)); end
                exp++;
            end
        end
        checks++;
        if (exp !== 200) begin errors++; $display("FAIL wrap_out_count: got %0d expected 200", exp); end
        checks++;
        if (rd_cnt !== 200) begin errors++; $display("FAIL wrap_read_count: got %0d expected 200", rd_cnt); end
        checks++;
        if (max_count > 64) begin errors++; $display("FAIL wrap_max_count: got %0d expected <= 64", max_count); end
        checks++;
        if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_seen: got %b expected 1", wrapped); end
    endtask

    task automatic test_reset_midstream();
        logic found;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            next_cycle();
            in_valid = 1'b1; in_data = 64'(100 + c); out_ready = 1'b0;
            #1;
            if (sram_oen && out_valid) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL midreset_setup: got %b expected 1 (read issued with word buffered)", found); end
        next_cycle();
        rst = 1'b1; in_valid = 1'b0;
        next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, count, in_ready} !== {1'b0, 7'd0, 1'b1} || out_data !== 64'd0) begin
            errors++; $display("FAIL midreset_state: got valid=%b count=%0d ready=%b data=%h expected 0 0 1 0", out_valid, count, in_ready, out_data);
        end
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            checks++;
            if ({out_valid, sram_wen, sram_oen} !== 3'b000) begin
                errors++; $display("FAIL midreset_stale_c%0d: got valid=%b wen=%b oen=%b expected 0 0 0", c, out_valid, sram_wen, sram_oen);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_idle();
        test_single();
        test_fill_stall();
        test_contention();
        test_wrap();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
